// File: rtl/stream_fifo_flushable_chk.sv
// Simulation-only observer for stream_fifo_flushable: flags input dropped by a
// flush and bounds the occupancy count.
module stream_fifo_flushable_chk #(
    parameter int unsigned  Depth = 4,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            flush_i,
    input logic            valid_i,
    input logic [CntW-1:0] usage
);
    // Sampled on every active edge outside reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (flush_i && valid_i) begin
                $warning("stream_fifo_flushable: valid_i dropped during flush");
            end
            assert (usage <= CntW'(Depth))
            else $error("stream_fifo_flushable: usage %0d exceeds Depth %0d", usage, Depth);
        end
    end

endmodule

// File: rtl/stream_fifo_flushable.sv
// Valid/ready stream FIFO with optional fall-through, synchronous flush/clear
// and a registered occupancy count.
module stream_fifo_flushable #(
    parameter type          T           = logic,
    parameter int unsigned  Depth       = 4,
    parameter bit           FallThrough = 1'b0,
    localparam int unsigned CntW        = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  T                data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output T                data_o,
    output logic [CntW-1:0] usage_o
);
    // A single-entry FIFO still needs a 1-bit pointer to index its storage.
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    T                mem_r [Depth];
    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    logic [CntW-1:0] usage_r;

    logic full_s;
    logic empty_s;
    logic block_s;
    logic push_s;
    logic pop_s;
    logic bypass_s;
    logic wr_en_s;
    logic rd_en_s;

    // Handshake and datapath decode; a same-cycle pass-through never touches storage.
    always_comb begin
        full_s   = (usage_r == FullCnt);
        empty_s  = (usage_r == {CntW{1'b0}});
        block_s  = flush_i | clr_i;
        ready_o  = !full_s && !block_s;
        valid_o  = (!empty_s || (FallThrough && valid_i)) && !block_s;
        push_s   = valid_i && ready_o;
        pop_s    = valid_o && ready_i;
        bypass_s = FallThrough && empty_s && push_s && pop_s;
        wr_en_s  = push_s && !bypass_s;
        rd_en_s  = pop_s && !bypass_s;
        if (FallThrough && empty_s) begin
            data_o = data_i;
        end else begin
            data_o = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy state; pointers wrap explicitly for non-power-of-two depths.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            usage_r  <= {CntW{1'b0}};
        end else if (block_s) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            usage_r  <= {CntW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= (wr_ptr_r == LastPtr) ? {PtrW{1'b0}} : wr_ptr_r + PtrW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= (rd_ptr_r == LastPtr) ? {PtrW{1'b0}} : rd_ptr_r + PtrW'(1);
            end
            usage_r <= usage_r + CntW'(wr_en_s) - CntW'(rd_en_s);
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    assign usage_o = usage_r;

endmodule

// File: tb/tb_stream_fifo_flushable.sv
// Directed scoreboard bench for stream_fifo_flushable across three configurations:
// inst 0 Depth=4/no fall-through, inst 1 Depth=3/no fall-through, inst 2 Depth=4/fall-through.
module tb_stream_fifo_flushable;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr     [3];
    logic       flush   [3];
    logic       vin     [3];
    logic       rdy_out [3];
    logic       vout    [3];
    logic       rdy_in  [3];
    logic [7:0] din     [3];
    logic [7:0] dout    [3];
    logic [2:0] use_a;
    logic [1:0] use_b;
    logic [2:0] use_c;

    int         depth_c [3] = '{4, 3, 4};
    bit         ft_c    [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] sb_q [$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    stream_fifo_flushable #(.T(logic [7:0]), .Depth(4), .FallThrough(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr[0]), .flush_i(flush[0]),
        .valid_i(vin[0]), .ready_o(rdy_out[0]), .data_i(din[0]),
        .valid_o(vout[0]), .ready_i(rdy_in[0]), .data_o(dout[0]), .usage_o(use_a)
    );
    stream_fifo_flushable #(.T(logic [7:0]), .Depth(3), .FallThrough(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr[1]), .flush_i(flush[1]),
        .valid_i(vin[1]), .ready_o(rdy_out[1]), .data_i(din[1]),
        .valid_o(vout[1]), .ready_i(rdy_in[1]), .data_o(dout[1]), .usage_o(use_b)
    );
    stream_fifo_flushable #(.T(logic [7:0]), .Depth(4), .FallThrough(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .clr_i(clr[2]), .flush_i(flush[2]),
        .valid_i(vin[2]), .ready_o(rdy_out[2]), .data_i(din[2]),
        .valid_o(vout[2]), .ready_i(rdy_in[2]), .data_o(dout[2]), .usage_o(use_c)
    );

    stream_fifo_flushable_chk #(.Depth(4)) chk_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .valid_i(vin[0]), .usage(use_a));
    stream_fifo_flushable_chk #(.Depth(3)) chk_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .valid_i(vin[1]), .usage(use_b));
    stream_fifo_flushable_chk #(.Depth(4)) chk_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[2]), .valid_i(vin[2]), .usage(use_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_use(input int k);
        case (k)
            0:       get_use = {29'd0, use_a};
            1:       get_use = {30'd0, use_b};
            default: get_use = {29'd0, use_c};
        endcase
    endfunction

    // One clock of instance k: drive at negedge, check handshake/data before the
    // rising edge against the scoreboard, then check usage after the edge.
    task automatic cycle(input int k, input logic v, input logic [7:0] d,
                         input logic r, input logic fl, input logic cl);
        logic       exp_rdy;
        logic       exp_vld;
        logic [7:0] exp_d;
        @(negedge clk);
        vin[k]   = v;
        din[k]   = d;
        rdy_in[k] = r;
        flush[k] = fl;
        clr[k]   = cl;
        #1;
        exp_rdy = (sb_q.size() < depth_c[k]) && !fl && !cl;
        exp_vld = ((sb_q.size() != 0) || (ft_c[k] && v)) && !fl && !cl;
        chk("ready_o", {31'd0, rdy_out[k]}, {31'd0, exp_rdy});
        chk("valid_o", {31'd0, vout[k]}, {31'd0, exp_vld});
        if (v && exp_rdy) sb_q.push_back(d);
        if (exp_vld && r) begin
            exp_d = sb_q.pop_front();
            chk("data_o", {24'd0, dout[k]}, {24'd0, exp_d});
        end
        if (fl || cl) sb_q.delete();
        @(posedge clk);
        #1;
        chk("usage_o", get_use(k), sb_q.size());
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b0; flush[i] = 1'b0; vin[i] = 1'b0;
            rdy_in[i] = 1'b0; din[i] = 8'h00;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state on every configuration.
        for (int k = 0; k < 3; k++) cycle(k, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill Depth=4 with consumer stalled, attempt a fifth push, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Depth=3 streaming: ten back-to-back transfers wrap both pointers.
        for (int i = 0; i < 10; i++) cycle(1, 1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        cycle(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fall-through: empty pass-through, then a stored word, then mixed.
        cycle(2, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        cycle(2, 1'b1, 8'hB6, 1'b0, 1'b0, 1'b0);
        cycle(2, 1'b1, 8'hC7, 1'b1, 1'b0, 1'b0);
        cycle(2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with three entries held and valid input present; dropped word never appears.
        for (int i = 0; i < 3; i++) cycle(0, 1'b1, 8'h21 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(0, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        cycle(0, 1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Clear together with flush, on fall-through instance holding two words.
        cycle(2, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        cycle(2, 1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        cycle(2, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        cycle(2, 1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
        cycle(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Full with push and pop offered: pop wins, push accepted next cycle.
        for (int i = 0; i < 4; i++) cycle(0, 1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        cycle(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges with two entries held.
        cycle(0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        cycle(0, 1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vin[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid_o", {31'd0, vout[0]}, 32'd0);
        chk("rst_ready_o", {31'd0, rdy_out[0]}, 32'd1);
        chk("rst_usage_o", get_use(0), 32'd0);
        #1 rst = 1'b0;
        sb_q.delete();
        cycle(0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_fifo_flushable.md
STREAM_FIFO_FLUSHABLE -- requirements
Module: stream_fifo_flushable

Interface
REQ-001 The block SHALL have parameter T (type, default logic): payload type.
REQ-002 The block SHALL have parameter Depth (int unsigned, default 4): number of entries, legal range 1..256.
REQ-003 The block SHALL have parameter FallThrough (bit, default 1'b0): when 1, an empty FIFO presents its input on the output in the same cycle.
REQ-004 The block SHALL have localparam CntW = $clog2(Depth+1): width of usage_o.
REQ-005 clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset; asynchronous, active-high.
REQ-007 clr_i  in  1  synchronous clear; empties the FIFO.
REQ-008 flush_i  in  1  synchronous flush; discards all entries and blocks handshakes this cycle.
REQ-009 valid_i  in  1  upstream valid.
REQ-010 ready_o  out  1  upstream ready.
REQ-011 data_i  in  T  upstream payload.
REQ-012 valid_o  out  1  downstream valid.
REQ-013 ready_i  in  1  downstream ready.
REQ-014 data_o  out  T  downstream payload.
REQ-015 usage_o  out  CntW  number of stored entries.

Function
REQ-016 push = valid_i && ready_o; pop = valid_o && ready_i; both are evaluated only when flush_i=0 and clr_i=0.
REQ-017 ready_o = !full && !flush_i && !clr_i; ready_o SHALL NOT depend on ready_i.
REQ-018 valid_o = (!empty || (FallThrough && valid_i)) && !flush_i && !clr_i.
REQ-019 data_o = head entry when !empty; data_i when empty and FallThrough=1; the value when valid_o=0 is don't-care.
REQ-020 FallThrough=0: first-in to first-out latency SHALL be 1 cycle; a word pushed into an empty FIFO SHALL appear on valid_o the next cycle.
REQ-021 FallThrough=1, empty, push and pop in the same cycle: the word SHALL pass combinationally and SHALL NOT be written; usage_o stays 0.
REQ-022 Push and pop in the same non-empty cycle: usage_o SHALL be unchanged, and write and read pointers SHALL each advance by 1.
REQ-023 Full (usage_o==Depth): ready_o=0; a pop frees a slot visible to ready_o the next cycle.
REQ-024 Read and write pointers SHALL wrap from Depth-1 to 0, including when Depth is not a power of two.
REQ-025 flush_i=1: the next cycle SHALL have usage_o=0 and both pointers=0; valid_i data presented during the flush cycle SHALL be dropped.
REQ-026 clr_i SHALL behave identically to flush_i and take priority over all other inputs; clr_i and flush_i both high SHALL behave as clr_i.
REQ-027 usage_o SHALL be registered and SHALL never exceed Depth.
REQ-028 Storage contents SHALL NOT be reset; only pointers and count are reset.

Reset
REQ-029 rst_i=1 SHALL asynchronously force both pointers to 0 and usage_o to 0, giving valid_o=0 and ready_o=1 (with flush_i=0).
REQ-030 Reset asserted mid-stream SHALL discard all entries; after release the first push SHALL be the first word out.

Structure
REQ-031 No shared package is needed; all constants are local parameters.
REQ-032 The design SHALL be a single module with no sub-modules; storage is a register array of Depth entries of T.
REQ-033 A simulation-only assertion SHALL warn when flush_i && valid_i, and SHALL check usage_o<=Depth.

Verification
REQ-034 Depth=4, FallThrough=0: push 0x1..0x4 with ready_i=0 -> ready_o=0 after the 4th push and usage_o=4; then ready_i=1 -> out 0x1,0x2,0x3,0x4 in order.
REQ-035 Depth=3: run 10 back-to-back transfers with ready_i=1 -> in-order output and a pointer wrap at 2->0; usage_o stays 1 steady-state.
REQ-036 FallThrough=1, empty: valid_i=1, data_i=0xA5, ready_i=1 -> valid_o=1 and data_o=0xA5 in the same cycle; usage_o stays 0.
REQ-037 Hold 3 entries, assert flush_i for 1 cycle with valid_i=1 -> valid_o=0 and ready_o=0 that cycle; the next cycle has usage_o=0 and the dropped input is never output.
REQ-038 Hold 2 entries, pulse rst_i asynchronously between clock edges -> valid_o=0 immediately; then push 0x7 -> first output is 0x7.
REQ-039 Full FIFO with pop and push both offered -> pop occurs, push is refused that cycle (ready_o=0), and the push is accepted the next cycle.
